// File: rtl/qc12864_bus_arbiter.sv
// Two-source arbiter for the QC12864 (ST7920) parallel bus: turns each accepted
// 9-bit {rs, data} word into one full write cycle, with burst ownership and round-robin handoff.
module qc12864_bus_arbiter #(
  parameter int SETUP_CYC    = 2,
  parameter int E_HIGH_CYC   = 8,
  parameter int GAP_CYC      = 100,
  parameter int LONG_GAP_CYC = 2000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_i,
  input  logic [8:0] word0_i,
  output logic       ack0_o,
  input  logic       req1_i,
  input  logic [8:0] word1_i,
  output logic       ack1_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_db_o
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_e;

  localparam logic [15:0] SETUP_LD  = 16'(SETUP_CYC);
  localparam logic [15:0] STROBE_LD = 16'(E_HIGH_CYC - 1);
  localparam logic [15:0] GAP_LD    = 16'(GAP_CYC - 1);
  localparam logic [15:0] LGAP_LD   = 16'(LONG_GAP_CYC - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [1:0]  grant_q;
  logic        prio_q;
  logic        ack0_q, ack1_q, busy_q, lcd_rs_q, lcd_e_q;
  logic [7:0]  lcd_db_q;

  logic [1:0]       req;
  logic [1:0][8:0]  word;
  logic             sel_vld, sel;
  logic             is_clr;
  logic [15:0]      gap_ld;

  assign req  = {req1_i, req0_i};
  assign word = {word1_i, word0_i};

  // Owner keeps the bus while it holds req; otherwise the requester not served last wins.
  always_comb begin
    sel_vld = 1'b1;
    sel     = 1'b0;
    if (grant_q[0] && req[0])      sel = 1'b0;
    else if (grant_q[1] && req[1]) sel = 1'b1;
    else if (&req)                 sel = prio_q;
    else if (req[0])               sel = 1'b0;
    else if (req[1])               sel = 1'b1;
    else                           sel_vld = 1'b0;
  end

  assign is_clr = !lcd_rs_q && (lcd_db_q == 8'h01);
  assign gap_ld = is_clr ? LGAP_LD : GAP_LD;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= '0;
      prio_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_e_q  <= 1'b0;
      lcd_db_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            grant_q  <= sel ? 2'b10 : 2'b01;
            ack0_q   <= !sel;
            ack1_q   <= sel;
            prio_q   <= !sel;
            lcd_rs_q <= word[sel][8];
            lcd_db_q <= word[sel][7:0];
            cnt_q    <= SETUP_LD;
            busy_q   <= 1'b1;
            state_q  <= SETUP;
          end else begin
            grant_q <= 2'b00;
          end
        end
        SETUP: begin
          if (cnt_q == 16'd0) begin
            lcd_e_q <= 1'b1;
            cnt_q   <= STROBE_LD;
            state_q <= STROBE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        STROBE: begin
          if (cnt_q == 16'd0) begin
            lcd_e_q <= 1'b0;
            cnt_q   <= gap_ld;
            // A one-cycle gap is just the IDLE cycle itself.
            if (gap_ld == 16'd0) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= GAP;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        GAP: begin
          if (cnt_q <= 16'd1) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack0_o   = ack0_q;
  assign ack1_o   = ack1_q;
  assign grant_o  = grant_q;
  assign busy_o   = busy_q;
  assign lcd_rs_o = lcd_rs_q;
  assign lcd_rw_o = 1'b0;
  assign lcd_e_o  = lcd_e_q;
  assign lcd_db_o = lcd_db_q;

endmodule

// File: tb/tb_qc12864_bus_arbiter.sv
// Directed bench for qc12864_bus_arbiter: expected acks queued at drive time, checked on ack.
module tb_qc12864_bus_arbiter;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [8:0] word0 = '0, word1 = '0;
  logic       ack0, ack1, busy, lcd_rs, lcd_rw, lcd_e;
  logic [1:0] grant;
  logic [7:0] lcd_db;

  qc12864_bus_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .word0_i(word0), .ack0_o(ack0),
    .req1_i(req1), .word1_i(word1), .ack1_o(ack1),
    .grant_o(grant), .busy_o(busy),
    .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_e_o(lcd_e), .lcd_db_o(lcd_db)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int who; logic [8:0] w; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int who, input logic [8:0] w);
    exp_t e;
    e.who = who;
    e.w   = w;
    sb.push_back(e);
  endtask

  task automatic score(input int who);
    exp_t e;
    chk("sb_nonempty", 32'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ack_who", who, e.who);
      chk("lcd_rs", lcd_rs, e.w[8]);
      chk("lcd_db", lcd_db, e.w[7:0]);
      chk("grant", grant, (who == 1) ? 2 : 1);
      chk("busy", busy, 1);
      chk("lcd_rw", lcd_rw, 0);
    end
  endtask

  // Waits for the next ack; er/ef are the first/last cycles lcd_e was seen high meanwhile.
  task automatic wait_ack(input int budget, output int who, output int t, output int er, output int ef);
    bit got = 1'b0;
    who = -1; t = -1; er = -1; ef = -1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      chk("dual_ack", {31'b0, ack0 & ack1}, 0);
      if (lcd_e) begin
        if (er < 0) er = cyc;
        ef = cyc;
      end
      if (ack0 || ack1) begin
        got = 1'b1;
        who = ack1 ? 1 : 0;
        t   = cyc;
      end
    end
    chk("ack_seen", {31'b0, got}, 1);
    if (got) score(who);
  endtask

  // Runs the bus back to IDLE with no requests pending; no ack may appear.
  task automatic settle(input int budget, output int er, output int ef);
    bit done = 1'b0;
    er = -1; ef = -1;
    for (int i = 0; i < budget + 2 && !done; i++) begin
      @(negedge clk);
      chk("no_ack", {31'b0, ack0 | ack1}, 0);
      if (lcd_e) begin
        if (er < 0) er = cyc;
        ef = cyc;
      end
      if (!busy) done = 1'b1;
    end
    chk("idle_reached", {31'b0, done}, 1);
    repeat (2) @(negedge clk);
    chk("grant_released", grant, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int who, t, tp, er, ef, c;
    bit seen;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_rw", lcd_rw, 0);
    chk("rst_lcd_db", lcd_db, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, then a clear command, then a word after the long gap
    req0 = 1'b1; word0 = 9'h034; push(0, 9'h034); c = cyc;
    wait_ack(10, who, t, er, ef);
    chk("first_ack_lat", t, c + 1); tp = t;
    word0 = 9'h001; push(0, 9'h001);
    wait_ack(200, who, t, er, ef);
    chk("normal_spacing", t - tp, 111);
    chk("e_rise", er, tp + 3);
    chk("e_fall", ef, tp + 10); tp = t;
    word0 = 9'h034; push(0, 9'h034);
    wait_ack(2100, who, t, er, ef);
    chk("clear_spacing", t - tp, 2011);
    chk("clr_e_rise", er, tp + 3);
    chk("clr_e_fall", ef, tp + 10); tp = t;
    req0 = 1'b0;
    settle(200, er, ef);
    chk("last_e_rise", er, tp + 3);

    // Data write from requester 1
    req1 = 1'b1; word1 = 9'h1AA; push(1, 9'h1AA); c = cyc;
    wait_ack(10, who, t, er, ef);
    chk("data_ack_lat", t, c + 1); tp = t;
    word1 = 9'h1AB; push(1, 9'h1AB);
    wait_ack(200, who, t, er, ef);
    chk("data_spacing", t - tp, 111);
    req1 = 1'b0;
    settle(200, er, ef);

    // Burst lock: requester 0 keeps the bus for three words
    word0 = 9'h080; word1 = 9'h155;
    req0 = 1'b1; req1 = 1'b1; push(0, 9'h080);
    wait_ack(10, who, t, er, ef); tp = t;
    push(0, 9'h080);
    wait_ack(200, who, t, er, ef);
    chk("burst_spacing1", t - tp, 111); tp = t;
    word0 = 9'h1FF; push(0, 9'h1FF);
    wait_ack(200, who, t, er, ef);
    chk("burst_spacing2", t - tp, 111); tp = t;
    req0 = 1'b0; push(1, 9'h155);
    wait_ack(200, who, t, er, ef);
    chk("handoff_spacing", t - tp, 111);
    req1 = 1'b0;
    settle(200, er, ef);

    // Round-robin: one word each per round
    for (int r = 0; r < 3; r++) begin
      word0 = 9'(9'h100 + r); word1 = 9'(9'h020 + r);
      req0 = 1'b1; req1 = 1'b1;
      push(0, word0); push(1, word1);
      for (int k = 0; k < 2; k++) begin
        wait_ack(200, who, t, er, ef);
        if (who == 1) req1 = 1'b0; else req0 = 1'b0;
      end
      req0 = 1'b0; req1 = 1'b0;
      settle(200, er, ef);
    end

    // Reset in the middle of the E strobe
    word0 = 9'h0C0; req0 = 1'b1; push(0, 9'h0C0);
    wait_ack(10, who, t, er, ef);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (lcd_e) seen = 1'b1;
    end
    chk("e_before_rst", {31'b0, seen}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_lcd_e", lcd_e, 0);
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_lcd_db", lcd_db, 0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_ack", {31'b0, ack0 | ack1}, 0);
    end
    push(0, 9'h0C0);
    rst_n = 1'b1; c = cyc;
    wait_ack(5, who, t, er, ef);
    chk("reaccept_lat", t, c + 1); tp = t;
    req0 = 1'b0;
    settle(200, er, ef);
    chk("re_e_rise", er, tp + 3);
    chk("re_e_fall", ef, tp + 10);
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/qc12864_bus_arbiter.md
# qc12864_bus_arbiter

Shares the QC12864 (ST7920) parallel LCD bus between two word sources, e.g. the GDRAM initializer and a pixel/text writer. Each accepted 9-bit word is turned into one complete bus write cycle (RS/DB setup, E strobe, post-write gap). A requester keeps ownership for a burst while it holds its request, so GDRAM Y/X/data sequences are never interleaved. Ownership passes round-robin when a request is released.

## Interface
- SETUP_CYC, 2: cycles RS/DB are stable before E rises (≥1).
- E_HIGH_CYC, 8: cycles E is high (≥1).
- GAP_CYC, 100: cycles after E falls before the next word can be accepted (≥1).
- LONG_GAP_CYC, 2000: gap used instead of GAP_CYC for the clear command (rs=0, data=0x01). All four parameters are ≤65535.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- req0  in  1  requester 0 has a word / holds burst ownership
- word0  in  9  requester 0 word {rs, data[7:0]}
- ack0  out  1  one-cycle pulse: word0 accepted
- req1, word1, ack1: same as above for requester 1
- grant  out  2  one-hot current owner, 00 = none
- busy  out  1  bus cycle in progress (state ≠ IDLE)
- lcd_rs  out  1  LCD RS (0 = command, 1 = data)
- lcd_rw  out  1  LCD R/W, constant 0 (write only)
- lcd_e  out  1  LCD enable strobe
- lcd_db  out  8  LCD data bus

## Operation
- All outputs are registered. Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0x00, ack0=ack1=0, grant=00, busy=0, state=IDLE, round-robin pointer favours requester 0.
- States: IDLE → SETUP → STROBE → GAP → IDLE. A 16-bit down-counter times SETUP, STROBE and GAP.
- IDLE, ownership:
  - If the current owner's req is high, accept the owner's word.
  - Otherwise clear grant. If any req is high, grant the higher-priority requester and accept its word in the same cycle. The requester not served last has priority; after reset requester 0 has priority.
- Accept: pulse ack for the granted requester, latch rs/data onto lcd_rs/lcd_db, load SETUP_CYC, go to SETUP.
- The requester must hold its word stable while req is high until ack. After ack it either presents the next word or drops req.
- SETUP: E low. On expiry, raise lcd_e, load E_HIGH_CYC, go to STROBE.
- STROBE: E high. On expiry, drop lcd_e and load the gap (LONG_GAP_CYC if the latched word is rs=0 and data=0x01, else GAP_CYC). Go to GAP.
- GAP: lcd_rs/lcd_db stay held. On expiry, return to IDLE.
- req is sampled only in IDLE. If req drops during SETUP, STROBE or GAP, the in-flight word still completes, and ownership is released at the next IDLE.
- Asserting rst at any point forces the reset values immediately. The in-flight word is discarded and never acked again.

## Timing
- Ack at cycle T. lcd_rs/lcd_db are valid from T+1. lcd_e is high during T+SETUP_CYC+1 … T+SETUP_CYC+E_HIGH_CYC.
- Earliest next ack is at T+1+SETUP_CYC+E_HIGH_CYC+gap. With defaults this is T+111 for a normal word and T+2011 for a clear.
- If the bus is idle, the first ack comes in the first clock edge after req rises.
- At most one ack pulse per bus cycle. ack0 and ack1 are never high together.
- grant updates in the same cycle as the accepting ack. It returns to 00 in the IDLE cycle where the owner's req is low and no other req is high.

## Test plan
- Single word: req0=1, word0=0x034 after reset → ack0 at T. lcd_rs=0 and lcd_db=0x34 from T+1. lcd_e high T+3..T+10. Holding req0 with the next word gives the next ack0 at T+111.
- Clear gap: word0=0x001 → lcd_e high T+3..T+10. Next ack at T+2011 (not T+111).
- Data write: word1=0x1AA alone → grant=10, lcd_rs=1, lcd_db=0xAA, normal 100-cycle gap.
- Burst lock: req0 and req1 both rise together after reset → grant=01. req0 is held for 3 words (0x080, 0x080, 0x1FF), giving three ack0 with no ack1. req0 drops after the 3rd ack → ack1 at the next IDLE, grant=10.
- Round-robin: both requesters pulse req for one word each, repeatedly → acks alternate 0,1,0,1.
- Reset mid-strobe: rst=0 during STROBE → lcd_e, grant and busy go to 0 asynchronously, with no ack. After rst=1 with req0 held, the word is re-accepted and lcd_e timing restarts from a fresh T.
